// File: rtl/mult_seq_param.sv
// Parametrised sequential multiply / multiply-accumulate unit.
// One shifted A_CHUNK x B_CHUNK partial product is added per cycle under a start/busy/done handshake.
module mult_seq_param #(
  parameter int A_WIDTH = 32,
  parameter int B_WIDTH = 32,
  parameter int A_CHUNK = 8,
  parameter int B_CHUNK = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       accumulate,
  input  logic [A_WIDTH-1:0]         a,
  input  logic [B_WIDTH-1:0]         b,
  output logic                       busy,
  output logic                       done,
  output logic [A_WIDTH+B_WIDTH-1:0] product
);

  localparam int NA      = A_WIDTH / A_CHUNK;
  localparam int NB      = B_WIDTH / B_CHUNK;
  localparam int NPP     = NA * NB;
  localparam int P_WIDTH = A_WIDTH + B_WIDTH;
  localparam int PP_W    = A_CHUNK + B_CHUNK;
  localparam int IA_W    = (NA > 1) ? $clog2(NA) : 1;
  localparam int IB_W    = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [IA_W-1:0] IA_LAST = IA_W'(NA - 1);
  localparam logic [IB_W-1:0] IB_LAST = IB_W'(NB - 1);

  if ((A_WIDTH % A_CHUNK) != 0) begin : g_bad_a_chunk
    $error("mult_seq_param: A_WIDTH must be a multiple of A_CHUNK");
  end
  if ((B_WIDTH % B_CHUNK) != 0) begin : g_bad_b_chunk
    $error("mult_seq_param: B_WIDTH must be a multiple of B_CHUNK");
  end
  if (NPP < 1) begin : g_bad_npp
    $error("mult_seq_param: at least one partial product is required");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [IA_W-1:0]      ia;
  logic [IB_W-1:0]      ib;
  logic [A_WIDTH-1:0]   a_lat;
  logic [B_WIDTH-1:0]   b_lat;
  logic [P_WIDTH-1:0]   pp_shift_p0;
  logic                 last_pp;
  logic                 accept;

  // Unsigned chunk product, zero-extended to the full result width and placed at its weight.
  function automatic logic [P_WIDTH-1:0] partial_product(
    input logic [A_WIDTH-1:0] op_a,
    input logic [B_WIDTH-1:0] op_b,
    input int                 ia_i,
    input int                 ib_i
  );
    logic [A_CHUNK-1:0] a_slice;
    logic [B_CHUNK-1:0] b_slice;
    logic [PP_W-1:0]    pp;
    a_slice = A_CHUNK'(op_a >> (ia_i * A_CHUNK));
    b_slice = B_CHUNK'(op_b >> (ib_i * B_CHUNK));
    pp      = PP_W'(a_slice) * PP_W'(b_slice);
    return P_WIDTH'(pp) << (ia_i * A_CHUNK + ib_i * B_CHUNK);
  endfunction

  assign pp_shift_p0 = partial_product(a_lat, b_lat, int'(ia), int'(ib));
  assign last_pp     = (ia == IA_LAST) && (ib == IB_LAST);
  assign accept      = start && ((state == S_IDLE) || (state == S_DONE));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_CALC;
      S_CALC:  if (last_pp) state_nxt = S_DONE;
      S_DONE:  state_nxt = start ? S_CALC : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_CALC);
    done = (state == S_DONE);
  end

  // Operand capture: only meaningful once a start is accepted, so no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_lat <= a;
      b_lat <= b;
    end
  end

  // Accumulator and slice counters; ia runs fastest, ib advances when ia wraps.
  always_ff @(posedge clk) begin
    if (!reset) begin
      product <= '0;
      ia      <= '0;
      ib      <= '0;
    end else if (accept) begin
      if (!accumulate) product <= '0;
      ia <= '0;
      ib <= '0;
    end else if (state == S_CALC) begin
      product <= product + pp_shift_p0;
      if (ia == IA_LAST) begin
        ia <= '0;
        ib <= (ib == IB_LAST) ? '0 : ib + 1'b1;
      end else begin
        ia <= ia + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mult_seq_param.sv
// Directed scoreboard bench for mult_seq_param: default 32x32/8x16 instance and a 16x16/4x8 instance.
module tb_mult_seq_param;

  logic        clk = 1'b0;
  logic        reset;
  logic        start1, acc1;
  logic [31:0] a1, b1;
  logic        busy1, done1;
  logic [63:0] product1;
  logic        start2, acc2;
  logic [15:0] a2, b2;
  logic        busy2, done2;
  logic [31:0] product2;

  int checks   = 0;
  int failures = 0;

  logic [63:0] q1[$];
  logic [31:0] q2[$];

  always #5 clk = ~clk;

  mult_seq_param dut1 (
    .clk(clk), .reset(reset), .start(start1), .accumulate(acc1),
    .a(a1), .b(b1), .busy(busy1), .done(done1), .product(product1)
  );

  mult_seq_param #(.A_WIDTH(16), .B_WIDTH(16), .A_CHUNK(4), .B_CHUNK(8)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .accumulate(acc2),
    .a(a2), .b(b2), .busy(busy2), .done(done2), .product(product2)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  // Monitors: pop the expected product whenever done is seen; done must never last two cycles.
  logic prev_done1 = 1'b0;
  logic prev_done2 = 1'b0;

  always @(negedge clk) begin
    if (prev_done1) chk("dut1_done_single_cycle", {63'd0, done1}, 64'd0);
    if (done1) begin
      if (q1.size() == 0) chk("dut1_unexpected_done", 64'd1, 64'd0);
      else chk("dut1_product", product1, q1.pop_front());
    end
    prev_done1 = done1;
  end

  always @(negedge clk) begin
    if (prev_done2) chk("dut2_done_single_cycle", {63'd0, done2}, 64'd0);
    if (done2) begin
      if (q2.size() == 0) chk("dut2_unexpected_done", 64'd1, 64'd0);
      else chk("dut2_product", {32'd0, product2}, {32'd0, q2.pop_front()});
    end
    prev_done2 = done2;
  end

  // Called #1 after a rising edge; the start is sampled on the next edge (edge k).
  // inj > 0 pulses start with a=b=5 after edge k+inj, which must be ignored.
  task automatic do_op(input bit sel, input logic [31:0] av, input logic [31:0] bv,
                       input bit acc, input logic [63:0] exp, input int inj);
    int  n;
    logic cd, cb;
    if (sel) begin
      a2 = av[15:0]; b2 = bv[15:0]; acc2 = acc; start2 = 1'b1;
      q2.push_back(exp[31:0]);
    end else begin
      a1 = av; b1 = bv; acc1 = acc; start1 = 1'b1;
      q1.push_back(exp);
    end
    @(posedge clk); #1;
    start1 = 1'b0; start2 = 1'b0;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      cd = sel ? done2 : done1;
      cb = sel ? busy2 : busy1;
      if (cd) begin
        n = i;
        break;
      end
      chk("busy_during_calc", {63'd0, cb}, 64'd1);
      if (i == inj) begin
        if (sel) begin start2 = 1'b1; a2 = 16'd5; b2 = 16'd5; end
        else     begin start1 = 1'b1; a1 = 32'd5; b1 = 32'd5; end
      end
      if (i == inj + 1) begin
        start1 = 1'b0; start2 = 1'b0;
      end
    end
    start1 = 1'b0; start2 = 1'b0;
    chk("done_latency", 64'(n), 64'd8);
    if (n != 0) chk("busy_low_at_done", {63'd0, sel ? busy2 : busy1}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    start1 = 1'b0; acc1 = 1'b0; a1 = '0; b1 = '0;
    start2 = 1'b0; acc2 = 1'b0; a2 = '0; b2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_product1", product1, 64'd0);
    chk("reset_busy1", {63'd0, busy1}, 64'd0);
    chk("reset_done1", {63'd0, done1}, 64'd0);
    chk("reset_product2", {32'd0, product2}, 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Single chunk partial products spread across the result
    do_op(1'b0, 32'h0000_00FF, 32'hFFFF_0000, 1'b0, 64'h0000_00FE_FF01_0000, 0);
    @(posedge clk); #1;

    // All-ones, then accumulate with wrap
    do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 0);
    @(posedge clk); #1;
    do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFC_0000_0002, 0);
    @(posedge clk); #1;

    // Back-to-back start issued in the DONE cycle
    do_op(1'b0, 32'h10, 32'h10, 1'b0, 64'h100, 0);
    do_op(1'b0, 32'h2, 32'h3, 1'b1, 64'h106, 0);
    @(posedge clk); #1;

    // Start pulse three cycles into CALC is ignored
    do_op(1'b0, 32'h1234, 32'h5678, 1'b0, 64'h0626_0060, 3);
    @(posedge clk); #1;

    // Reset during the fourth CALC cycle abandons the operation
    a1 = 32'hFFFF_FFFF; b1 = 32'hFFFF_FFFF; acc1 = 1'b1; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    chk("abort_product", product1, 64'd0);
    chk("abort_busy", {63'd0, busy1}, 64'd0);
    chk("abort_done", {63'd0, done1}, 64'd0);
    repeat (10) begin @(posedge clk); #1; end
    chk("abort_no_late_done", {63'd0, done1}, 64'd0);
    do_op(1'b0, 32'd3, 32'd7, 1'b1, 64'h15, 0);
    @(posedge clk); #1;

    // Narrow instance: 16x16 with 4x8 chunks
    do_op(1'b1, 32'hABCD, 32'h1234, 1'b0, 64'h0C37_4FA4, 0);

    repeat (4) begin @(posedge clk); #1; end
    chk("scoreboard1_drained", 64'(q1.size()), 64'd0);
    chk("scoreboard2_drained", 64'(q2.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
